pdm_demod: RTL
==============

# pdm_demod

Pulse-density demodulator: the receive-side counterpart of the audio PDM DAC. It generates a PDM bit clock and samples a 1-bit PDM stream from a PDM microphone or an external modulator. The stream is filtered and decimated through a 2nd-order CIC (sinc²) filter into signed PCM samples. Each sample is presented with a one-cycle valid strobe for the audio/SoC side.

## Interface
Parameters:
- SAMPLE_BITS, 12, width of the signed output sample. Must satisfy SAMPLE_BITS <= 2*DEC_BITS.
- DEC_BITS, 6, log2 of the decimation ratio R (R = 2**DEC_BITS PDM bits per output sample).
- CLK_DIV, 4, system clocks per PDM bit. Must be even and >= 4.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- resetn  input  1  asynchronous, active-low reset.
- pdm_in  input  1  PDM data, asynchronous to clk.
- pdm_clk  output  1  PDM bit clock to the modulator/microphone.
- dout  output  SAMPLE_BITS  signed PCM sample.
- dout_valid  output  1  one-cycle strobe; dout is new on this cycle.

## Operation
- Reset clears every register:
  - pdm_clk=0, dout=0, dout_valid=0.
  - Divider, decimation counter, integrators, comb delays and warm-up counter are all 0.
- Input synchronizer: pdm_in passes through 2 flops (pdm_s) before any use.
- Clock divider `div`:
  - Counts 0..CLK_DIV-1 and wraps.
  - pdm_clk is registered and equals 1 when div >= CLK_DIV/2. Each bit period is therefore CLK_DIV/2 cycles low, then CLK_DIV/2 cycles high.
  - Internal strobe ce is high on the cycle where div == CLK_DIV-1. This is the last high cycle, before the falling edge.
- Integrators run only on ce. Width W = 2*DEC_BITS+1, unsigned, modulo 2^W; wrap is intentional and not an error.
  - i1 <= i1 + pdm_s
  - i2 <= i2 + (i1 + pdm_s), i.e. i2 accumulates the updated i1.
- Decimation counter `dcnt` (DEC_BITS wide):
  - Increments on ce.
  - On the ce where dcnt == R-1 it wraps to 0 and raises the internal strobe dec for one cycle, on the following cycle.
- Comb stages (W bits, modulo), pipelined, one register stage each:
  - c1 = i2 - i2_d
  - c2 = c1 - c1_d
  - The delay registers update only on the decimation path.
- Scaling:
  - raw = c2, in the range 0..R².
  - Centered value: raw - 2^(2*DEC_BITS-1).
  - Arithmetic shift right by (2*DEC_BITS - SAMPLE_BITS).
  - Saturate to [-2^(SAMPLE_BITS-1), 2^(SAMPLE_BITS-1)-1].
- Resulting mapping:
  - All-zero stream gives the minimum code.
  - 50% density gives 0.
  - All-ones stream gives max+1, which saturates to max.
  - This is the inverse of the DAC mapping: density = (d + 2^(S-1)) / 2^S.
- Warm-up:
  - A 2-bit counter counts completed decimation periods after reset.
  - dout_valid is suppressed, and dout is held, for the first 2 decimation periods while the comb history fills.
  - From the 3rd period on, every period produces exactly one dout_valid.
- Reset mid-operation (resetn low at any time):
  - Immediately returns to reset state, including pdm_clk=0.
  - Warm-up restarts from 0 after release.

## Timing
- pdm_clk period = CLK_DIV clocks. First rising edge of pdm_clk is CLK_DIV/2 cycles after reset release.
- Pin-to-sample latency: a pdm_in value must be stable for at least 3 clk edges before a ce edge to be captured (2 synchronizer flops plus the ce sample).
- Output latency: dout/dout_valid update on the 3rd rising edge after the edge that integrates the R-th bit of a period (dec, comb1, comb2/scale-saturate-register).
- Output rate: one dout_valid every R*CLK_DIV clocks, exactly; dout_valid is never high for 2 consecutive cycles.
- dout holds its value between strobes.

## Test plan
All scenarios use SAMPLE_BITS=12, DEC_BITS=6, CLK_DIV=4 (R=64, strobe period 256 clks).
- Reset behaviour: hold resetn low, then release.
  - While low: pdm_clk=0, dout=0, dout_valid=0.
  - After release: pdm_clk waveform is 0,0,1,1 repeating.
  - No dout_valid within the first 512+3 clks.
- pdm_in held at 0: every dout_valid after warm-up has dout = -2048; strobes are exactly 256 clks apart.
- pdm_in held at 1: dout = +2047 (saturated); no wrap to negative.
- Alternating 1,0 on successive ce: dout = 0 exactly on every post-warm-up strobe.
- Loopback: bench first-order PDM modulator with constant input +1000 (12-bit, same mapping as the DAC), advanced once per ce. Every post-warm-up dout is within ±64 of +1000.
- Reset mid-period: assert resetn during dcnt≈30 of a running all-ones stream. Required response:
  - All outputs return to reset values immediately.
  - After release, the first dout_valid appears only after 2 full new periods, with dout = +2047.

Source files
------------

// File: rtl/pdm_demod.sv
// pdm_demod: generates the PDM bit clock, samples a 1-bit PDM stream and
// decimates it through a 2nd-order CIC (sinc^2) into signed PCM samples.
// Pipeline after the last integrated bit of a period:
//   dec strobe -> comb1 register -> comb2 register -> scale/saturate register
module pdm_demod #(
  parameter int SAMPLE_BITS = 12,
  parameter int DEC_BITS    = 6,
  parameter int CLK_DIV     = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          pdm_in,
  output logic                          pdm_clk,
  output logic signed [SAMPLE_BITS-1:0] dout,
  output logic                          dout_valid
);

  localparam int W     = 2*DEC_BITS + 1;
  localparam int DIVW  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int SHIFT = 2*DEC_BITS - SAMPLE_BITS;

  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
  localparam logic [DIVW-1:0] DIV_HALF = DIVW'(CLK_DIV / 2);
  localparam logic [W:0]      CENTER   = (W+1)'(2**(2*DEC_BITS-1));
  localparam logic signed [W:0] SAT_MAX = (W+1)'(2**(SAMPLE_BITS-1) - 1);
  localparam logic signed [W:0] SAT_MIN = (W+1)'(-(2**(SAMPLE_BITS-1)));

  logic [1:0]          sync_q;
  logic                pdm_s;
  logic [DIVW-1:0]     div_q, div_d;
  logic                pdm_clk_q, pdm_clk_d;
  logic                ce;
  logic [W-1:0]        i1_q, i1_d;
  logic [W-1:0]        i2_q, i2_d;
  logic [DEC_BITS-1:0] dcnt_q, dcnt_d;
  logic                dec_q, dec_d;
  logic [1:0]          warm_q, warm_d;
  logic [W-1:0]        i2_dly_q, i2_dly_d;
  logic [W-1:0]        c1_q, c1_d;
  logic                p1_q, p1_d;
  logic                en1_q, en1_d;
  logic [W-1:0]        c1_dly_q, c1_dly_d;
  logic [W-1:0]        c2_q, c2_d;
  logic                p2_q, p2_d;
  logic                en2_q, en2_d;
  logic signed [SAMPLE_BITS-1:0] dout_q, dout_d;
  logic                valid_q, valid_d;

  logic signed [W:0]   centered;
  logic signed [W:0]   shifted;
  logic signed [W:0]   sat;

  assign pdm_s      = sync_q[1];
  assign ce         = (div_q == DIV_LAST);
  assign pdm_clk    = pdm_clk_q;
  assign dout       = dout_q;
  assign dout_valid = valid_q;

  // Two-flop synchronizer for the asynchronous PDM data pin.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sync_q <= 2'b00;
    else         sync_q <= {sync_q[0], pdm_in};
  end

  // Divider, integrators, decimation counter and warm-up tracking.
  always_comb begin
    div_d     = ce ? '0 : div_q + DIVW'(1);
    pdm_clk_d = (div_d >= DIV_HALF);
    i1_d      = i1_q;
    i2_d      = i2_q;
    dcnt_d    = dcnt_q;
    dec_d     = 1'b0;
    warm_d    = warm_q;
    if (ce) begin
      i1_d   = i1_q + W'(pdm_s);
      i2_d   = i2_q + i1_d;
      dcnt_d = dcnt_q + DEC_BITS'(1);
      dec_d  = (dcnt_q == '1);
    end
    if (dec_q && (warm_q != 2'd2)) warm_d = warm_q + 2'd1;
  end

  // Comb pipeline and output scaling; history registers move only on
  // their own pipeline pulse, so the comb sees one sample per period.
  always_comb begin
    i2_dly_d = i2_dly_q;
    c1_d     = c1_q;
    c1_dly_d = c1_dly_q;
    c2_d     = c2_q;
    p1_d     = dec_q;
    en1_d    = dec_q && (warm_q == 2'd2);
    p2_d     = p1_q;
    en2_d    = p1_q && en1_q;
    if (dec_q) begin
      c1_d     = i2_q - i2_dly_q;
      i2_dly_d = i2_q;
    end
    if (p1_q) begin
      c2_d     = c1_q - c1_dly_q;
      c1_dly_d = c1_q;
    end
    centered = $signed({1'b0, c2_q} - CENTER);
    shifted  = centered >>> SHIFT;
    if (shifted > SAT_MAX)      sat = SAT_MAX;
    else if (shifted < SAT_MIN) sat = SAT_MIN;
    else                        sat = shifted;
    valid_d = p2_q && en2_q;
    dout_d  = valid_d ? sat[SAMPLE_BITS-1:0] : dout_q;
  end

  // State registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q     <= '0;
      pdm_clk_q <= 1'b0;
      i1_q      <= '0;
      i2_q      <= '0;
      dcnt_q    <= '0;
      dec_q     <= 1'b0;
      warm_q    <= 2'd0;
      i2_dly_q  <= '0;
      c1_q      <= '0;
      p1_q      <= 1'b0;
      en1_q     <= 1'b0;
      c1_dly_q  <= '0;
      c2_q      <= '0;
      p2_q      <= 1'b0;
      en2_q     <= 1'b0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      div_q     <= div_d;
      pdm_clk_q <= pdm_clk_d;
      i1_q      <= i1_d;
      i2_q      <= i2_d;
      dcnt_q    <= dcnt_d;
      dec_q     <= dec_d;
      warm_q    <= warm_d;
      i2_dly_q  <= i2_dly_d;
      c1_q      <= c1_d;
      p1_q      <= p1_d;
      en1_q     <= en1_d;
      c1_dly_q  <= c1_dly_d;
      c2_q      <= c2_d;
      p2_q      <= p2_d;
      en2_q     <= en2_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
    end
  end

endmodule
